// File: rtl/hdlc_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_rx_frame_ctrl
// Brief    : HDLC receive frame sequencer. Opens on a flag, buffers destuffed
//            bytes, closes on the next flag or discards on abort, then holds
//            the frame for the register interface.
//            Optional FCS check: define HDLC_RX_FCS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hdlc_rx_frame_ctrl #(
  parameter int BUF_DEPTH = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx_Enable,
  input  logic       Rx_FlagDetect,
  input  logic       Rx_AbortDetect,
  input  logic       Rx_NewByte,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_RdBuff,
  input  logic       Rx_Drop,
  output logic       Rx_ValidFrame,
  output logic       Rx_WrBuff,
  output logic       Rx_AbortSignal,
  output logic       Rx_Overflow,
  output logic       Rx_FrameError,
  output logic       Rx_Ready,
  output logic       Rx_EoF,
  output logic [7:0] Rx_FrameSize,
  output logic [7:0] Rx_DataBuff
);

  localparam int         AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [7:0] DEPTH_C = 8'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] wptr_q, rptr_q, size_q, dbuf_q;
  logic       valid_q, wr_q, abort_q, ovf_q, ferr_q, ready_q, eof_q;
  logic [7:0] mem_q [BUF_DEPTH];

  logic       store_d, ovf_d, ferr_d;
  logic [7:0] cnt_d, size_d;

  // A byte arriving with the closing flag is still stored and counted.
  assign store_d = Rx_Enable && (state_q == S_FRAME) && !Rx_AbortDetect &&
                   Rx_NewByte && (wptr_q < DEPTH_C);
  assign cnt_d   = wptr_q + {7'd0, store_d};
  assign ovf_d   = ovf_q || (Rx_NewByte && !store_d);

`ifdef HDLC_RX_FCS_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign crc_d = store_d ? crc_byte(crc_q, Rx_Data) : crc_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                   crc_q <= 16'hFFFF;
    else if (!Rx_Enable || state_q != S_FRAME)  crc_q <= 16'hFFFF;
    else                                        crc_q <= crc_d;
  end

  // Overflowed frames skip the CRC; runts are flagged with a zero payload.
  always_comb begin
    size_d = 8'd0;
    ferr_d = 1'b0;
    if (ovf_d) begin
      size_d = DEPTH_C - 8'd2;
    end else if (cnt_d < 8'd3) begin
      ferr_d = 1'b1;
    end else begin
      size_d = cnt_d - 8'd2;
      ferr_d = (crc_d != 16'hF0B8);
    end
  end
`else
  assign size_d = cnt_d;
  assign ferr_d = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (store_d) mem_q[wptr_q[AW-1:0]] <= Rx_Data;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      wptr_q  <= 8'd0;
      rptr_q  <= 8'd0;
      size_q  <= 8'd0;
      dbuf_q  <= 8'd0;
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ready_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      eof_q   <= 1'b0;
      if (!Rx_Enable) begin
        state_q <= S_IDLE;
        wptr_q  <= 8'd0;
        rptr_q  <= 8'd0;
        size_q  <= 8'd0;
        dbuf_q  <= 8'd0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        ferr_q  <= 1'b0;
        ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (Rx_FlagDetect) begin
              state_q <= S_FRAME;
              valid_q <= 1'b1;
              wptr_q  <= 8'd0;
              ovf_q   <= 1'b0;
            end
          end
          S_FRAME: begin
            if (Rx_AbortDetect) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              abort_q <= 1'b1;
              wptr_q  <= 8'd0;
              ovf_q   <= 1'b0;
            end else begin
              wr_q   <= store_d;
              wptr_q <= cnt_d;
              ovf_q  <= ovf_d;
              // Flags with nothing stored are shared or back-to-back: keep waiting.
              if (Rx_FlagDetect && cnt_d != 8'd0) begin
                state_q <= S_DONE;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
                eof_q   <= 1'b1;
                size_q  <= size_d;
                ferr_q  <= ferr_d;
                rptr_q  <= 8'd0;
              end
            end
          end
          S_DONE: begin
            if (Rx_Drop || (Rx_RdBuff && size_q == 8'd0)) begin
              state_q <= S_IDLE;
              ready_q <= 1'b0;
              ovf_q   <= 1'b0;
              ferr_q  <= 1'b0;
            end else if (Rx_RdBuff) begin
              dbuf_q <= mem_q[rptr_q[AW-1:0]];
              rptr_q <= rptr_q + 8'd1;
              if (rptr_q == size_q - 8'd1) begin
                state_q <= S_IDLE;
                ready_q <= 1'b0;
                ovf_q   <= 1'b0;
                ferr_q  <= 1'b0;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign Rx_ValidFrame  = valid_q;
  assign Rx_WrBuff      = wr_q;
  assign Rx_AbortSignal = abort_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_Ready       = ready_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameSize   = size_q;
  assign Rx_DataBuff    = dbuf_q;

endmodule
`default_nettype wire

// File: doc/hdlc_rx_frame_ctrl.md
# hdlc_rx_frame_ctrl

Frame-level controller for the HDLC receive path. It sits between the Rx flag/abort detector and byte deserializer on one side and the CPU-facing register interface on the other. It sequences each frame: it opens on a flag, writes destuffed bytes into a 128-byte frame buffer, and closes on the next flag or discards the frame on abort. It then holds the frame, with size and status, until software reads or drops it.

## Interface
- `BUF_DEPTH`, 128: frame buffer depth in bytes. Must be at most 255.
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Rx_Enable`  in  1  receiver enable. Low forces IDLE and clears all status.
- `Rx_FlagDetect`  in  1  one-cycle pulse: flag 01111110 received.
- `Rx_AbortDetect`  in  1  one-cycle pulse: abort pattern received.
- `Rx_NewByte`  in  1  one-cycle strobe: `Rx_Data` holds a complete destuffed byte.
- `Rx_Data`  in  8  received byte.
- `Rx_RdBuff`  in  1  one-cycle read request from the register interface.
- `Rx_Drop`  in  1  one-cycle software request to discard the held frame.
- `Rx_ValidFrame`  out  1  high while state is FRAME.
- `Rx_WrBuff`  out  1  one-cycle pulse per byte stored in the buffer.
- `Rx_AbortSignal`  out  1  one-cycle pulse after an abort during a valid frame.
- `Rx_Overflow`  out  1  sticky: the held frame exceeded `BUF_DEPTH`.
- `Rx_FrameError`  out  1  sticky: the held frame failed the FCS or length check.
- `Rx_Ready`  out  1  a complete frame is held and readable.
- `Rx_EoF`  out  1  one-cycle pulse when a frame closes.
- `Rx_FrameSize`  out  8  payload byte count of the held frame.
- `Rx_DataBuff`  out  8  last byte read from the buffer.

## Operation
States: IDLE, FRAME, DONE.

- **IDLE**
  - `Rx_FlagDetect` with `Rx_Enable` high: go to FRAME, clear the write pointer.
  - All other inputs are ignored.
- **FRAME**
  - `Rx_NewByte` with write pointer < `BUF_DEPTH`: store the byte at the pointer, pulse `Rx_WrBuff`, increment the pointer.
  - `Rx_NewByte` with the buffer full: discard the byte, set `Rx_Overflow`.
  - `Rx_FlagDetect` with zero bytes stored: stay in FRAME. This covers shared and back-to-back flags.
  - `Rx_FlagDetect` with at least one byte stored: go to DONE, set `Rx_Ready`, pulse `Rx_EoF`, latch `Rx_FrameSize`.
  - `Rx_AbortDetect`: pulse `Rx_AbortSignal`, discard the frame, go to IDLE.
- **DONE**
  - Bus activity is ignored; frames arriving now are lost.
  - `Rx_RdBuff`: `Rx_DataBuff` takes `buf[rptr]`, then `rptr` increments.
  - After the read at `rptr = Rx_FrameSize-1`: clear `Rx_Ready`, `Rx_Overflow` and `Rx_FrameError`; go to IDLE.
  - `Rx_Drop`: clear the same status, go to IDLE.
  - `Rx_RdBuff` when `Rx_FrameSize` = 0: same as `Rx_Drop`.

Priority, highest first:
1. `Rx_Enable` low
2. `Rx_AbortDetect`
3. `Rx_FlagDetect`
4. `Rx_NewByte`

- `Rx_NewByte` and a closing `Rx_FlagDetect` in the same cycle: the byte is stored first and counted in the frame.
- `Rx_Drop` beats `Rx_RdBuff` in the same cycle.
- On overflow, `Rx_FrameSize` saturates at `BUF_DEPTH`; the frame is still presented with `Rx_Overflow` high.

## Timing
- Reset values:
  - State is IDLE; all pointers are 0.
  - `Rx_ValidFrame`, `Rx_WrBuff`, `Rx_AbortSignal`, `Rx_Overflow`, `Rx_FrameError`, `Rx_Ready` and `Rx_EoF` are 0.
  - `Rx_FrameSize` and `Rx_DataBuff` are 0x00.
- All outputs are registered.
- `Rx_ValidFrame` rises the cycle after the opening `Rx_FlagDetect`.
- `Rx_WrBuff` pulses the cycle after `Rx_NewByte`.
- `Rx_AbortSignal` pulses the cycle after `Rx_AbortDetect` sampled with `Rx_ValidFrame` high. `Rx_ValidFrame` falls in the same cycle.
- `Rx_EoF`, `Rx_Ready` and `Rx_FrameSize` are valid the cycle after the closing flag.
- `Rx_DataBuff` is valid the cycle after `Rx_RdBuff`.
- Reset or `Rx_Enable` low mid-frame returns to IDLE within one cycle. No `Rx_AbortSignal` or `Rx_EoF` pulse is produced.

## Configuration
- `HDLC_RX_FCS_EN` defined:
  - A CRC-16/X.25 register (polynomial 0x1021 reflected, init 0xFFFF, bytes processed LSB first) runs over every stored byte, including the two trailing FCS bytes.
  - At close, a residue other than 0xF0B8 sets `Rx_FrameError`.
  - `Rx_FrameSize` is the stored count minus 2.
  - Frames with fewer than 3 stored bytes set `Rx_FrameError` with `Rx_FrameSize` = 0.
  - On overflow, the CRC is not checked and `Rx_FrameSize` = `BUF_DEPTH`-2.
- `HDLC_RX_FCS_EN` undefined:
  - No CRC logic is built; `Rx_FrameError` is tied to 0.
  - `Rx_FrameSize` is the stored byte count.

## Test plan
- Flag, bytes 0x11 0x22 0x33, flag, FCS off:
  - 3 `Rx_WrBuff` pulses; `Rx_EoF` 1 cycle after the second flag; `Rx_FrameSize` = 3.
  - 3 `Rx_RdBuff` yield 0x11, 0x22, 0x33; `Rx_Ready` falls after the third read.
- Flag, 2 bytes, `Rx_AbortDetect`: `Rx_AbortSignal` high exactly 1 cycle later; `Rx_Ready` stays 0; state returns to IDLE.
- Flag, 130 bytes, flag: 128 `Rx_WrBuff` pulses; `Rx_Overflow` = 1; `Rx_FrameSize` = 128; `Rx_Drop` clears both `Rx_Overflow` and `Rx_Ready`.
- FCS on, payload 0x01 0x02 plus the correct FCS bytes: `Rx_FrameError` = 0, `Rx_FrameSize` = 2. Same frame with one FCS bit flipped: `Rx_FrameError` = 1.
- Flag, flag, flag, byte 0xAA, flag: single frame with `Rx_FrameSize` = 1. `Rx_Enable` dropped mid-frame: all outputs return to reset values the next cycle.
